// File: rtl/proc_pkg.sv
// Shared definitions for the program-loader slice: image geometry and loader FSM states.
// The loader's optional checksum stage (LOADER_CHECKSUM_EN) uses ST_CHK from this enum.
package proc_pkg;

    localparam int PROG_WORDS  = 16;
    localparam int PROG_ADDR_W = 4;
    localparam int INST_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: packs big-endian byte pairs into instruction words and writes them
// sequentially while holding the CPU. Optional trailing XOR checksum byte with `define LOADER_CHECKSUM_EN.
module program_loader
    import proc_pkg::*;
#(
    parameter int WORDS  = PROG_WORDS,
    parameter int ADDR_W = PROG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [INST_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    loader_state_t     r_state;
    loader_state_t     w_state_next;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [INST_W-1:0] r_wr_data;

    logic w_xfer;
    logic w_abort;
    logic w_load_start;
    logic w_last;
    logic w_take_hi;
    logic w_take_lo;

    assign w_xfer    = byte_valid && byte_ready;
    assign w_abort   = abort && (r_state != ST_IDLE);
    assign w_last    = (r_wr_addr == LAST_ADDR);
    // abort wins over any byte offered in the same cycle, so the byte is simply not taken.
    assign w_take_hi = (r_state == ST_HI) && w_xfer && !w_abort;
    assign w_take_lo = (r_state == ST_LO) && w_xfer && !w_abort;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_load_start = 1'b0;
        if (w_abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_state_next = ST_HI;
                        w_load_start = 1'b1;
                    end
                end
                ST_HI: begin
                    if (w_xfer) w_state_next = ST_LO;
                end
                ST_LO: begin
                    if (w_xfer) w_state_next = ST_WRITE;
                end
                ST_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_next = w_last ? ST_CHK : ST_HI;
`else
                    w_state_next = w_last ? ST_DONE : ST_HI;
`endif
                end
                ST_CHK: begin
`ifdef LOADER_CHECKSUM_EN
                    if (w_xfer) w_state_next = ST_DONE;
`else
                    w_state_next = ST_IDLE;
`endif
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // The address only advances when WRITE hands over to the next word, so it saturates at LAST_ADDR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            if (w_load_start) begin
                r_wr_addr <= '0;
            end else if ((r_state == ST_WRITE) && (w_state_next == ST_HI)) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
            if (w_take_hi) r_wr_data[15:8] <= byte_data;
            if (w_take_lo) r_wr_data[7:0]  <= byte_data;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_load_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_csum       <= '0;
            r_load_error <= 1'b0;
        end else if (w_load_start || w_abort) begin
            r_csum       <= '0;
            r_load_error <= 1'b0;
        end else begin
            if (w_take_hi || w_take_lo) r_csum <= r_csum ^ byte_data;
            if ((r_state == ST_CHK) && w_xfer) r_load_error <= (byte_data != r_csum);
        end
    end

    assign load_error = r_load_error;
    // A failed image keeps the CPU stalled even though the load itself is reported complete.
    assign cpu_hold   = (r_state == ST_HI) || (r_state == ST_LO) || (r_state == ST_WRITE)
                     || (r_state == ST_CHK) || ((r_state == ST_DONE) && r_load_error);
`else
    assign load_error = 1'b0;
    assign cpu_hold   = (r_state == ST_HI) || (r_state == ST_LO) || (r_state == ST_WRITE);
`endif

    assign byte_ready = (r_state == ST_HI) || (r_state == ST_LO) || (r_state == ST_CHK);
    assign wr_en      = (r_state == ST_WRITE);
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign load_done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader (default build): random images checked against an
// expected-write list derived directly from the image bytes.
module tb_program_loader;
    import proc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    program_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] img [32];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_writes = 0;
    logic       prev_wr  = 1'b0;
    bit         mon_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: word w of an image is simply {img[2w], img[2w+1]} written at address w.
    task automatic expect_words(input int n);
        wr_t e;
        for (int w = 0; w < n; w++) begin
            e.addr = w;
            e.data = {16'h0, img[2*w], img[2*w+1]};
            exp_q.push_back(e);
        end
    endtask

    task automatic new_image();
        for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_en) begin
                wr_t e;
                n_writes++;
                check("wr_single_cycle", prev_wr, 0);
                check("wr_pending", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                end
            end
            prev_wr = wr_en;
        end
    end

    // Offer one byte after a random idle gap and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int n;
        bit acc;
        n   = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        acc = 1'b0;
        repeat (n) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int k = 0; k < 40 && !acc; k++) begin
            if (byte_ready) acc = 1'b1;
            @(negedge clk);
        end
        check("byte_accepted", acc, 1);
    endtask

    task automatic send_range(input int first, input int last, input int gap_max);
        for (int i = first; i <= last; i++) send_byte(img[i], gap_max);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string phase);
        check({phase, "_byte_ready"}, byte_ready, 0);
        check({phase, "_wr_en"},      wr_en,      0);
        check({phase, "_wr_addr"},    wr_addr,    0);
        check({phase, "_wr_data"},    wr_data,    0);
        check({phase, "_cpu_hold"},   cpu_hold,   0);
        check({phase, "_load_done"},  load_done,  0);
        check({phase, "_load_error"}, load_error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        mon_en     = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // Back-to-back bytes, directed first words.
        new_image();
        img[0] = 8'h1E; img[1] = 8'h09; img[2] = 8'h12; img[3] = 8'h01;
        expect_words(16);
        w0 = n_writes;
        pulse_start();
        check("t1_hold_on_start", cpu_hold, 1);
        check("t1_ready_in_hi", byte_ready, 1);
        check("t1_done_low", load_done, 0);
        send_range(0, 31, 0);
        byte_valid = 1'b0;
        check("t1_last_wr_en", wr_en, 1);
        check("t1_done_not_yet", load_done, 0);
        check("t1_hold_not_yet", cpu_hold, 1);
        @(negedge clk);
        check("t1_load_done", load_done, 1);
        check("t1_hold_released", cpu_hold, 0);
        check("t1_ready_done", byte_ready, 0);
        check("t1_write_count", n_writes - w0, 16);
        check("t1_queue_empty", exp_q.size(), 0);

        // Random gaps, restarted from DONE.
        new_image();
        expect_words(16);
        w0 = n_writes;
        pulse_start();
        send_range(0, 31, 5);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t2_load_done", load_done, 1);
        check("t2_write_count", n_writes - w0, 16);
        check("t2_queue_empty", exp_q.size(), 0);

        // Abort after five bytes, with a byte offered in the abort cycle.
        new_image();
        expect_words(2);
        pulse_start();
        send_range(0, 4, 2);
        byte_data  = img[5];
        byte_valid = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t3_abort_hold", cpu_hold, 0);
        check("t3_abort_done", load_done, 0);
        check("t3_abort_ready", byte_ready, 0);
        check("t3_abort_wr_en", wr_en, 0);
        repeat (8) @(negedge clk);
        byte_valid = 1'b0;
        check("t3_partial_written", exp_q.size(), 0);
        new_image();
        expect_words(16);
        w0 = n_writes;
        pulse_start();
        send_range(0, 31, 2);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_reload_done", load_done, 1);
        check("t3_reload_count", n_writes - w0, 16);

        // start while waiting for a low byte is ignored.
        new_image();
        expect_words(16);
        pulse_start();
        send_range(0, 6, 1);
        byte_valid = 1'b0;
        pulse_start();
        check("t4_addr_kept", wr_addr, 3);
        check("t4_hi_kept", wr_data[15:8], img[6]);
        check("t4_still_loading", byte_ready, 1);
        send_range(7, 31, 1);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_load_done", load_done, 1);
        check("t4_queue_empty", exp_q.size(), 0);

        // Asynchronous reset during a WRITE cycle.
        new_image();
        expect_words(16);
        pulse_start();
        send_range(0, 9, 1);
        byte_valid = 1'b0;
        check("t5_in_write", wr_en, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_wr_en", wr_en, 0);
        check("t5_async_hold", cpu_hold, 0);
        check("t5_async_ready", byte_ready, 0);
        exp_q.delete();
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("t5_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
